// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte-stream requesters share one UART
// transmitter; a granted requester keeps the transmitter until its message ends.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, START, DONE} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic          last;
  logic [IW-1:0] pick;
  logic          pick_valid;
  logic [IW-1:0] owner_next;

  // Search upward from ptr with wrap; iterating downward lets the nearest hit win.
  always_comb begin
    int j;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    j          = 0;
    pick       = ptr;
    pick_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        pick       = IW'(j);
        pick_valid = 1'b1;
      end
    end
  end

  assign owner_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is synchronous; every state and output register is cleared here.
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      last      <= 1'b0;
      grant     <= '0;
      req_ready <= '0;
      tx_send   <= 1'b0;
      tx_data   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; later branch writes override these pulse defaults.
      tx_send   <= 1'b0;
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick;
            grant <= NUM_REQ'(1) << pick;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (req[owner]) begin
            tx_data   <= req_data[{owner, 3'b000} +: 8];
            tx_send   <= 1'b1;
            req_ready <= NUM_REQ'(1) << owner;
            last      <= req_last[owner];
            state     <= START;
          end else begin
            grant <= '0;
            ptr   <= owner_next;
            state <= IDLE;
          end
        end
        START: begin
          if (tx_busy) state <= DONE;
        end
        DONE: begin
          if (!tx_busy) begin
            // The latched last flag ends the message even if req stays high for the next one.
            if (last || !req[owner]) begin
              grant <= '0;
              ptr   <= owner_next;
              state <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: message-level requester drivers, a UART busy model and a
// rule-based arbiter model compared against the DUT on every falling edge.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int FRAME = 100;  // 10 bits at 10 clocks per bit

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic           tx_busy;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // requester drivers
  logic [7:0] msg [N][8];
  int         len [N];
  int         idx [N];
  int         gap [N];
  bit         active [N];
  bit         auto_en [N];
  int         len_max = 4;
  int         gap_max = 20;

  // arbiter model
  int         ptr_m;
  bit         load_next;
  logic [N-1:0] grant_prev;
  bit         inflight;
  logic [7:0] hold_data;
  bit         last_sent;
  int         exp_sends;

  // UART model
  int         raise_cnt;
  int         hold;
  bit         fell;

  // observation logs
  logic [N-1:0] grant_log [$];
  logic [7:0]   send_log [$];
  int           ready_cnt [N];
  logic [N-1:0] act_prev;

  function automatic logic [N-1:0] rr_pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return N'(1) << ((p + k) % N);
    return '0;
  endfunction

  function automatic int idx_of(logic [N-1:0] g);
    for (int i = 0; i < N; i++)
      if (g[i]) return i;
    return 0;
  endfunction

  function automatic logic [63:0] pack_sends();
    logic [63:0] v = '0;
    for (int k = 0; k < send_log.size() && k < 8; k++) v[8*k +: 8] = send_log[k];
    return v;
  endfunction

  function automatic logic [63:0] pack_grants();
    logic [63:0] v = '0;
    for (int k = 0; k < grant_log.size() && k < 16; k++) v[4*k +: 4] = 4'(grant_log[k]);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_msg(input int i, input int n, input logic [63:0] bytes);
    for (int k = 0; k < n; k++) msg[i][k] = bytes[8*k +: 8];
    len[i]    = n;
    idx[i]    = 0;
    active[i] = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!active[i] && auto_en[i]) begin
        if (gap[i] > 0) gap[i]--;
        else start_msg(i, $urandom_range(1, len_max), {$urandom, $urandom});
      end
      req[i] = active[i];
      if (active[i]) begin
        req_data[8*i +: 8] = msg[i][idx[i]];
        req_last[i]        = (idx[i] == len[i] - 1);
      end else begin
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
  endtask

  // Runs at each falling edge: req/rst still hold the values the last rising edge saw.
  task automatic model_step();
    bit           busy_fell_prev;
    bit           load_now;
    bit           exp_send;
    int           g;
    logic [N-1:0] exp_grant;
    busy_fell_prev = fell;
    fell           = 1'b0;
    if (rst) begin
      check("rst_grant", grant, '0);
      check("rst_tx_send", tx_send, '0);
      check("rst_req_ready", req_ready, '0);
      check("rst_tx_data", tx_data, '0);
      ptr_m = 0; load_next = 1'b0; grant_prev = '0; inflight = 1'b0;
      tx_busy = 1'b0; raise_cnt = -1; hold = 0; act_prev = '0;
      for (int i = 0; i < N; i++) active[i] = 1'b0;
      return;
    end
    load_now  = load_next;
    load_next = 1'b0;
    g         = idx_of(grant_prev);
    exp_send  = load_now && req[g];
    if (grant_prev == '0) begin
      exp_grant = rr_pick(req, ptr_m);
      if (exp_grant != '0) load_next = 1'b1;
    end else if ((load_now && !req[g]) || (busy_fell_prev && (last_sent || !req[g]))) begin
      exp_grant = '0;
      ptr_m     = (g + 1) % N;
    end else begin
      exp_grant = grant_prev;
      if (busy_fell_prev) load_next = 1'b1;
    end
    check("grant", grant, exp_grant);
    check("tx_send", tx_send, exp_send);
    check("req_ready", req_ready, exp_send ? grant_prev : '0);
    if (exp_send) begin
      check("tx_data", tx_data, msg[g][idx[g]]);
      hold_data = msg[g][idx[g]];
      inflight  = 1'b1;
      last_sent = (idx[g] == len[g] - 1);
      exp_sends++;
      idx[g]++;
      if (idx[g] == len[g]) begin
        active[g] = 1'b0;
        gap[g]    = $urandom_range(0, gap_max);
      end
    end else if (inflight) begin
      check("tx_data_hold", tx_data, hold_data);
    end
    if (busy_fell_prev) inflight = 1'b0;
    grant_prev = exp_grant;

    if (grant != '0 && grant != act_prev) grant_log.push_back(grant);
    act_prev = grant;
    if (tx_send) send_log.push_back(tx_data);
    for (int i = 0; i < N; i++) if (req_ready[i]) ready_cnt[i]++;

    if (tx_send) raise_cnt = $urandom_range(0, 1);
    if (raise_cnt == 0) begin
      tx_busy = 1'b1; hold = FRAME; raise_cnt = -1;
    end else if (raise_cnt > 0) begin
      raise_cnt--;
    end else if (tx_busy) begin
      hold--;
      if (hold == 0) begin
        tx_busy = 1'b0;
        fell    = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    send_log.delete();
    exp_sends = 0;
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
  endtask

  function automatic bit all_idle();
    bit any = 1'b0;
    for (int i = 0; i < N; i++) any |= active[i];
    return !any && grant == '0 && !tx_busy && raise_cnt < 0 && !load_next;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    check(name, n < budget, 1'b1);
  endtask

  task automatic start_all_single();
    for (int i = 0; i < N; i++) start_msg(i, 1, 64'(8'hA0 + i));
    drive();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; tx_busy = 1'b0; raise_cnt = -1; hold = 0; fell = 1'b0;
    ptr_m = 0; load_next = 1'b0; grant_prev = '0; inflight = 1'b0;
    hold_data = '0; last_sent = 1'b0; exp_sends = 0; act_prev = '0;
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0; auto_en[i] = 1'b0; gap[i] = 0; len[i] = 1; idx[i] = 0;
    end
    drive();

    // single requester, three-byte message
    do_reset();
    clear_logs();
    start_msg(1, 3, 64'h0A6948);
    drive();
    wait_idle("single_timeout", 1000);
    check("single_count", send_log.size(), 3);
    check("single_bytes", pack_sends(), 64'h0A6948);
    check("single_ready", ready_cnt[1], 3);
    check("single_grants", pack_grants(), 64'h2);
    check("single_release", grant, '0);

    // contention with continuous single-byte messages
    do_reset();
    clear_logs();
    len_max = 1; gap_max = 0;
    for (int i = 0; i < N; i++) begin auto_en[i] = 1'b1; gap[i] = 0; end
    drive();
    n = 0;
    while (grant_log.size() < 5 && n < 2000) begin tick(); n++; end
    check("rr_order", pack_grants() & 64'hFFFFF, 64'h18421);
    for (int i = 0; i < N; i++) auto_en[i] = 1'b0;
    wait_idle("rr_timeout", 2000);

    // lock: requester 2 arrives during requester 0's second byte
    do_reset();
    clear_logs();
    start_msg(0, 4, 64'h44332211);
    drive();
    n = 0;
    while (send_log.size() < 2 && n < 500) begin tick(); n++; end
    start_msg(2, 1, 64'h55);
    drive();
    wait_idle("lock_timeout", 2000);
    check("lock_grants", pack_grants(), 64'h41);
    check("lock_bytes", pack_sends(), 64'h5544332211);

    // withdrawal in DONE of byte 1 of 3
    do_reset();
    clear_logs();
    start_msg(3, 3, 64'h333231);
    drive();
    n = 0;
    while (!tx_busy && n < 20) begin tick(); n++; end
    tick();
    tick();
    active[3] = 1'b0;
    drive();
    wait_idle("withdraw_timeout", 500);
    check("withdraw_bytes", pack_sends(), 64'h31);
    check("withdraw_grants", pack_grants(), 64'h8);
    start_all_single();
    tick();
    check("withdraw_ptr", grant, 4'b0001);
    wait_idle("withdraw_drain", 2000);

    // withdrawal during LOAD: no byte sent, pointer moves past the owner
    clear_logs();
    start_msg(1, 2, 64'h6261);
    drive();
    tick();
    check("loadwd_grant", grant, 4'b0010);
    active[1] = 1'b0;
    drive();
    wait_idle("loadwd_timeout", 100);
    check("loadwd_sends", send_log.size(), 0);
    start_all_single();
    tick();
    check("loadwd_ptr", grant, 4'b0100);
    wait_idle("loadwd_drain", 2000);

    // reset mid-message
    clear_logs();
    start_msg(1, 3, 64'hC3C2C1);
    drive();
    n = 0;
    while (!tx_send && n < 20) begin tick(); n++; end
    rst = 1'b1;
    tick();
    check("midrst_grant", grant, '0);
    check("midrst_send", tx_send, 1'b0);
    rst = 1'b0;
    start_msg(2, 1, 64'h77);
    drive();
    tick();
    check("midrst_regrant", grant, 4'b0100);
    wait_idle("midrst_timeout", 500);
    check("midrst_count", send_log.size(), 2);
    check("midrst_last", send_log[send_log.size() - 1], 8'h77);

    // randomized traffic
    clear_logs();
    len_max = 4; gap_max = 40;
    for (int i = 0; i < N; i++) begin auto_en[i] = 1'b1; gap[i] = $urandom_range(0, 10); end
    repeat (8000) tick();
    for (int i = 0; i < N; i++) auto_en[i] = 1'b0;
    wait_idle("rand_timeout", 3000);
    check("rand_sends", send_log.size(), exp_sends);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
